oled_init_sequencer: RTL and testbench

- Drives the SSD1331-class OLED power-up/init command stream into the SPI master (TX byte / DV / Ready handshake).
- Also owns the panel's RES_n, CS_n and D/C pins.
- Sits directly upstream of the SPI master: on a start pulse it resets the panel, then streams a fixed command table one byte per SPI transaction under a single CS_n window, then pulses done.

---
 rtl/oled_pkg.sv | 57 +++++
 rtl/oled_init_sequencer_if.sv | 26 ++
 rtl/oled_delay_counter.sv | 28 ++
 rtl/oled_init_sequencer.sv | 164 ++++++++++++++++
 tb/tb_oled_init_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 power-up sequencer: opcodes, the
// init command table, FSM state encoding and a parameter helper.
package oled_pkg;

  localparam int unsigned INIT_LEN = 13;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned BYTE_W   = 8;

  // SSD1331 opcodes and their argument bytes used during init
  localparam logic [BYTE_W-1:0] DISPLAY_OFF        = 8'hAE;
  localparam logic [BYTE_W-1:0] SET_REMAP          = 8'hA0;
  localparam logic [BYTE_W-1:0] REMAP_CFG          = 8'h72;
  localparam logic [BYTE_W-1:0] SET_START_LINE     = 8'hA1;
  localparam logic [BYTE_W-1:0] START_LINE_0       = 8'h00;
  localparam logic [BYTE_W-1:0] SET_DISP_OFFSET    = 8'hA2;
  localparam logic [BYTE_W-1:0] DISP_OFFSET_0      = 8'h00;
  localparam logic [BYTE_W-1:0] NORMAL_DISPLAY     = 8'hA4;
  localparam logic [BYTE_W-1:0] SET_MULTIPLEX      = 8'hA8;
  localparam logic [BYTE_W-1:0] MUX_RATIO_64       = 8'h3F;
  localparam logic [BYTE_W-1:0] SET_MASTER_CFG     = 8'hAD;
  localparam logic [BYTE_W-1:0] MASTER_CFG_EXT_VCC = 8'h8E;
  localparam logic [BYTE_W-1:0] DISPLAY_ON         = 8'hAF;

  localparam logic [BYTE_W-1:0] INIT_TABLE [INIT_LEN] = '{
    DISPLAY_OFF,
    SET_REMAP,       REMAP_CFG,
    SET_START_LINE,  START_LINE_0,
    SET_DISP_OFFSET, DISP_OFFSET_0,
    NORMAL_DISPLAY,
    SET_MULTIPLEX,   MUX_RATIO_64,
    SET_MASTER_CFG,  MASTER_CFG_EXT_VCC,
    DISPLAY_ON
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RES_LOW,
    ST_RES_WAIT,
    ST_CS_SETUP,
    ST_SEND,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_CS_HOLD
  } state_t;

  // Largest of the four delay parameters; sizes the shared counter
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/oled_init_sequencer_if.sv
// Control/SPI-handshake/panel-pin bundle of the OLED init sequencer.
// master: the sequencer side (drives TX byte/DV and panel pins).
// slave : the surrounding logic (drives start and the SPI master's Ready).
interface oled_init_sequencer_if;
  logic       i_Start;
  logic       o_Busy;
  logic       o_Done;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready;
  logic       o_OLED_RES_n;
  logic       o_OLED_CS_n;
  logic       o_OLED_DC;

  modport master (
    input  i_Start, i_TX_Ready,
    output o_Busy, o_Done, o_TX_Byte, o_TX_DV,
    output o_OLED_RES_n, o_OLED_CS_n, o_OLED_DC
  );

  modport slave (
    output i_Start, i_TX_Ready,
    input  o_Busy, o_Done, o_TX_Byte, o_TX_DV,
    input  o_OLED_RES_n, o_OLED_CS_n, o_OLED_DC
  );
endinterface

// File: rtl/oled_delay_counter.sv
// Loadable down-counter with a zero flag, shared by the sequencer's delay states.
// Ports: clk, rst (async, active high), load/load_val (load takes priority),
//        zero_c (combinational: count is zero). Counting stops at zero.
module oled_delay_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/oled_init_sequencer.sv
// SSD1331 power-up sequencer: on start, pulses the panel reset, then streams
// the init command table to an SPI master one byte per Ready handshake inside
// a single CS_n window, then pulses done.
// Ports: i_Clk, i_Rst (async, active high), bus (master modport):
//   i_Start, o_Busy, o_Done, o_TX_Byte, o_TX_DV, i_TX_Ready,
//   o_OLED_RES_n, o_OLED_CS_n, o_OLED_DC.
module oled_init_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned RESET_LOW_CLKS  = 250,
  parameter int unsigned RESET_WAIT_CLKS = 2500,
  parameter int unsigned CS_SETUP_CLKS   = 2,
  parameter int unsigned CS_HOLD_CLKS    = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  oled_init_sequencer_if.master  bus
);

  localparam int unsigned MAX_CLKS =
    max4(RESET_LOW_CLKS, RESET_WAIT_CLKS, CS_SETUP_CLKS, CS_HOLD_CLKS);
  localparam int unsigned CNT_W = $clog2(MAX_CLKS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  // Counter loads N-1 on state entry so each delay state lasts exactly N cycles
  localparam logic [CNT_W-1:0] LD_RES_LOW  = CNT_W'(RESET_LOW_CLKS - 1);
  localparam logic [CNT_W-1:0] LD_RES_WAIT = CNT_W'(RESET_WAIT_CLKS - 1);
  localparam logic [CNT_W-1:0] LD_CS_SETUP = CNT_W'(CS_SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] LD_CS_HOLD  = CNT_W'(CS_HOLD_CLKS - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next, idx_inc;
  logic               busy, busy_next;
  logic               done, done_next;
  logic [BYTE_W-1:0]  tx_byte, tx_byte_next;
  logic               tx_dv, tx_dv_next;
  logic               res_n, res_n_next;
  logic               cs_n, cs_n_next;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;

  oled_delay_counter #(.WIDTH(CNT_W)) u_delay (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero_c   (cnt_zero)
  );

  assign idx_inc = idx + IDX_W'(1);

  // State and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tx_byte <= '0;
      tx_dv   <= 1'b0;
      res_n   <= 1'b1;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      busy    <= busy_next;
      done    <= done_next;
      tx_byte <= tx_byte_next;
      tx_dv   <= tx_dv_next;
      res_n   <= res_n_next;
      cs_n    <= cs_n_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    busy_next    = busy;
    done_next    = 1'b0;
    tx_byte_next = tx_byte;
    tx_dv_next   = 1'b0;
    res_n_next   = res_n;
    cs_n_next    = cs_n;
    cnt_load     = 1'b0;
    cnt_val      = '0;

    unique case (state)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped
        if (bus.i_Start && !done) begin
          state_next = ST_RES_LOW;
          busy_next  = 1'b1;
          idx_next   = '0;
          res_n_next = 1'b0;
          cnt_load   = 1'b1;
          cnt_val    = LD_RES_LOW;
        end
      end
      ST_RES_LOW: begin
        if (cnt_zero) begin
          state_next = ST_RES_WAIT;
          res_n_next = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = LD_RES_WAIT;
        end
      end
      ST_RES_WAIT: begin
        if (cnt_zero) begin
          state_next   = ST_CS_SETUP;
          cs_n_next    = 1'b0;
          tx_byte_next = INIT_TABLE[0];
          cnt_load     = 1'b1;
          cnt_val      = LD_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_zero) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (bus.i_TX_Ready) begin
          tx_dv_next = 1'b1;
          state_next = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        // Ready low means the master has taken the byte
        if (!bus.i_TX_Ready) state_next = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.i_TX_Ready) begin
          if (idx < LAST_IDX) begin
            idx_next     = idx_inc;
            tx_byte_next = INIT_TABLE[idx_inc];
            state_next   = ST_SEND;
          end else begin
            state_next = ST_CS_HOLD;
            cnt_load   = 1'b1;
            cnt_val    = LD_CS_HOLD;
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt_zero) begin
          state_next = ST_IDLE;
          cs_n_next  = 1'b1;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.o_Busy       = busy;
  assign bus.o_Done       = done;
  assign bus.o_TX_Byte    = tx_byte;
  assign bus.o_TX_DV      = tx_dv;
  assign bus.o_OLED_RES_n = res_n;
  assign bus.o_OLED_CS_n  = cs_n;
  assign bus.o_OLED_DC    = 1'b0;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench for oled_init_sequencer with a simple SPI-master Ready model.
module tb_oled_init_sequencer;

  logic clk;
  logic rst;
  oled_init_sequencer_if bus();

  oled_init_sequencer #(
    .RESET_LOW_CLKS  (4),
    .RESET_WAIT_CLKS (8),
    .CS_SETUP_CLKS   (2),
    .CS_HOLD_CLKS    (2)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise = 0;
  int low_len  = 16;
  bit stall    = 1'b0;
  int fmt_err  = 0;
  int proto_err = 0;
  logic [7:0] byte_q [$];
  logic [7:0] exp_bytes [13] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
                                 8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hAF};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI master model: Ready drops the cycle after DV, returns low_len cycles later
  initial begin
    int  low_left;
    logic dv_s;
    low_left = 0;
    bus.i_TX_Ready = 1'b1;
    forever begin
      @(posedge clk);
      dv_s = bus.o_TX_DV;
      #1;
      if (stall) begin
        bus.i_TX_Ready = 1'b0;
        low_left = 0;
      end else if (dv_s === 1'b1) begin
        bus.i_TX_Ready = 1'b0;
        low_left = low_len;
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) begin
          bus.i_TX_Ready = 1'b1;
          last_rise = cyc;
        end
      end else if (bus.i_TX_Ready !== 1'b1) begin
        bus.i_TX_Ready = 1'b1;
        last_rise = cyc;
      end
    end
  end

  // Byte collector and protocol monitor (DC, CS during DV, Ready 1->0->1 between DVs)
  initial begin
    int hs;
    hs = 2;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) hs = 2;
      if (bus.o_OLED_DC !== 1'b0) fmt_err++;
      if (bus.o_TX_DV === 1'b1) begin
        byte_q.push_back(bus.o_TX_Byte);
        if (bus.o_OLED_CS_n !== 1'b0) fmt_err++;
        if (hs != 2) proto_err++;
        hs = 0;
      end else if (hs == 0 && bus.i_TX_Ready === 1'b0) begin
        hs = 1;
      end else if (hs == 1 && bus.i_TX_Ready === 1'b1) begin
        hs = 2;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pulse();
    @(negedge clk);
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (bus.o_Done !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > max_cycles) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 7;
    if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_Busy); end
    if (bus.o_Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.o_Done); end
    if (bus.o_TX_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", bus.o_TX_Byte); end
    if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", bus.o_TX_DV); end
    if (bus.o_OLED_RES_n !== 1'b1) begin n_fail++; $display("FAIL reset_res_n: got %b expected 1", bus.o_OLED_RES_n); end
    if (bus.o_OLED_CS_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", bus.o_OLED_CS_n); end
    if (bus.o_OLED_DC !== 1'b0) begin n_fail++; $display("FAIL reset_dc: got %b expected 0", bus.o_OLED_DC); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_Busy !== 1'b0 || bus.o_OLED_RES_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: busy=%b res_n=%b expected 0/1", bus.o_Busy, bus.o_OLED_RES_n);
    end
  endtask

  task automatic test_full_sequence();
    int base, fe, pe, low, wt, d;
    bit to;
    logic [7:0] got;
    base = byte_q.size(); fe = fmt_err; pe = proto_err;
    start_pulse();
    n_checks++;
    if (bus.o_Busy !== 1'b1 || bus.o_OLED_RES_n !== 1'b0) begin
      n_fail++; $display("FAIL full_start: busy=%b res_n=%b expected 1/0", bus.o_Busy, bus.o_OLED_RES_n);
    end
    low = 1;
    while (low < 1000) begin
      @(negedge clk);
      if (bus.o_OLED_RES_n === 1'b1) break;
      low++;
    end
    n_checks++;
    if (low != 4) begin n_fail++; $display("FAIL full_res_low: got %0d cycles expected 4", low); end
    wt = 0;
    while (bus.o_OLED_CS_n !== 1'b0 && wt < 1000) begin
      @(negedge clk);
      wt++;
    end
    n_checks++;
    if (wt != 8) begin n_fail++; $display("FAIL full_res_wait: got %0d cycles expected 8", wt); end
    d = 0;
    while (bus.o_TX_DV !== 1'b1 && d < 500) begin
      @(negedge clk);
      d++;
    end
    n_checks++;
    if (d < 2 || d >= 500) begin n_fail++; $display("FAIL full_cs_setup: got %0d cycles expected >=2", d); end
    wait_done(2000, to);
    n_checks += 4;
    if (to) begin n_fail++; $display("FAIL full_done_timeout: got timeout expected done"); end
    if (bus.o_OLED_CS_n !== 1'b1) begin n_fail++; $display("FAIL full_cs_rise: got %b expected 1 with done", bus.o_OLED_CS_n); end
    if (cyc - last_rise != 3) begin n_fail++; $display("FAIL full_done_latency: got %0d expected 3", cyc - last_rise); end
    if (byte_q.size() - base != 13) begin n_fail++; $display("FAIL full_count: got %0d expected 13", byte_q.size() - base); end
    for (int i = 0; i < 13; i++) begin
      got = (base + i < byte_q.size()) ? byte_q[base + i] : 8'hxx;
      n_checks++;
      if (got !== exp_bytes[i]) begin n_fail++; $display("FAIL full_byte%0d: got %h expected %h", i, got, exp_bytes[i]); end
    end
    n_checks += 2;
    if (fmt_err != fe) begin n_fail++; $display("FAIL full_dc_cs: got %0d errors expected 0", fmt_err - fe); end
    if (proto_err != pe) begin n_fail++; $display("FAIL full_handshake: got %0d errors expected 0", proto_err - pe); end
    @(negedge clk);
    n_checks++;
    if (bus.o_Done !== 1'b0 || bus.o_Busy !== 1'b0) begin
      n_fail++; $display("FAIL full_done_pulse: done=%b busy=%b expected 0/0", bus.o_Done, bus.o_Busy);
    end
  endtask

  task automatic test_start_ignored();
    int base, n;
    bit to;
    logic [7:0] got;
    base = byte_q.size();
    start_pulse();
    n = 0;
    while (byte_q.size() - base < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bus.i_Start = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_Start = 1'b0;
    wait_done(2000, to);
    n_checks += 2;
    if (to) begin n_fail++; $display("FAIL busy_done_timeout: got timeout expected done"); end
    if (byte_q.size() - base != 13) begin n_fail++; $display("FAIL busy_count: got %0d expected 13", byte_q.size() - base); end
    for (int i = 0; i < 13; i++) begin
      got = (base + i < byte_q.size()) ? byte_q[base + i] : 8'hxx;
      n_checks++;
      if (got !== exp_bytes[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h expected %h", i, got, exp_bytes[i]); end
    end
    // Start raised in the done cycle must be dropped
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    n_checks++;
    if (bus.o_Busy !== 1'b0 || bus.o_OLED_RES_n !== 1'b1) begin
      n_fail++; $display("FAIL done_cycle_start: busy=%b res_n=%b expected 0/1", bus.o_Busy, bus.o_OLED_RES_n);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (byte_q.size() - base != 13 || bus.o_Busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_no_restart: bytes=%0d busy=%b expected 13/0", byte_q.size() - base, bus.o_Busy);
    end
  endtask

  task automatic test_stalled_ready();
    int base, n;
    bit to;
    stall = 1'b1;
    repeat (3) @(negedge clk);
    base = byte_q.size();
    start_pulse();
    n = 0;
    while (bus.o_OLED_CS_n !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    n_checks += 2;
    if (byte_q.size() - base != 0) begin n_fail++; $display("FAIL stall_no_dv: got %0d bytes expected 0", byte_q.size() - base); end
    if (bus.o_Busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b expected 1", bus.o_Busy); end
    stall = 1'b0;
    n = 0;
    while (byte_q.size() - base < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (byte_q.size() - base != 1) begin n_fail++; $display("FAIL stall_single_dv: got %0d bytes expected 1", byte_q.size() - base); end
    else if (byte_q[base] !== 8'hAE) begin n_fail++; $display("FAIL stall_first_byte: got %h expected ae", byte_q[base]); end
    if (byte_q.size() - base == 0) begin n_fail++; $display("FAIL stall_first_byte: got none expected ae"); end
    wait_done(2000, to);
    n_checks++;
    if (to || byte_q.size() - base != 13) begin
      n_fail++; $display("FAIL stall_count: got %0d bytes timeout=%b expected 13/0", byte_q.size() - base, to);
    end
  endtask

  task automatic test_reset_mid();
    int base, base2, k, n;
    bit to;
    logic [7:0] got;
    base = byte_q.size();
    start_pulse();
    k = 0; n = 0;
    while (k < 7 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.o_TX_DV === 1'b1) k++;
    end
    #1 rst = 1'b1;
    #1;
    n_checks += 4;
    if (bus.o_OLED_CS_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cs_n: got %b expected 1", bus.o_OLED_CS_n); end
    if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dv: got %b expected 0", bus.o_TX_DV); end
    if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", bus.o_Busy); end
    if (bus.o_OLED_RES_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_res_n: got %b expected 1", bus.o_OLED_RES_n); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    base2 = byte_q.size();
    n_checks++;
    if (base2 - base != 7) begin n_fail++; $display("FAIL mid_rst_bytes: got %0d expected 7", base2 - base); end
    start_pulse();
    wait_done(2000, to);
    n_checks++;
    if (to || byte_q.size() - base2 != 13) begin
      n_fail++; $display("FAIL mid_replay_count: got %0d timeout=%b expected 13/0", byte_q.size() - base2, to);
    end
    for (int i = 0; i < 13; i++) begin
      got = (base2 + i < byte_q.size()) ? byte_q[base2 + i] : 8'hxx;
      n_checks++;
      if (got !== exp_bytes[i]) begin n_fail++; $display("FAIL mid_replay_byte%0d: got %h expected %h", i, got, exp_bytes[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit to;
    logic [7:0] got;
    base = byte_q.size();
    start_pulse();
    wait_done(2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL b2b_first_timeout: got timeout expected done"); end
    @(negedge clk);
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    n_checks++;
    if (bus.o_Busy !== 1'b1 || bus.o_OLED_RES_n !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart: busy=%b res_n=%b expected 1/0", bus.o_Busy, bus.o_OLED_RES_n);
    end
    wait_done(2000, to);
    n_checks += 2;
    if (to) begin n_fail++; $display("FAIL b2b_second_timeout: got timeout expected done"); end
    if (byte_q.size() - base != 26) begin n_fail++; $display("FAIL b2b_count: got %0d expected 26", byte_q.size() - base); end
    for (int i = 0; i < 26; i++) begin
      got = (base + i < byte_q.size()) ? byte_q[base + i] : 8'hxx;
      n_checks++;
      if (got !== exp_bytes[i % 13]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got, exp_bytes[i % 13]); end
    end
    @(negedge clk);
  endtask

  task automatic test_min_gap();
    int base, pe;
    bit to;
    logic [7:0] got;
    low_len = 1;
    base = byte_q.size(); pe = proto_err;
    start_pulse();
    wait_done(2000, to);
    n_checks += 4;
    if (to) begin n_fail++; $display("FAIL gap_timeout: got timeout expected done"); end
    if (byte_q.size() - base != 13) begin n_fail++; $display("FAIL gap_count: got %0d expected 13", byte_q.size() - base); end
    if (proto_err != pe) begin n_fail++; $display("FAIL gap_handshake: got %0d errors expected 0", proto_err - pe); end
    if (cyc - last_rise != 3) begin n_fail++; $display("FAIL gap_done_latency: got %0d expected 3", cyc - last_rise); end
    for (int i = 0; i < 13; i++) begin
      got = (base + i < byte_q.size()) ? byte_q[base + i] : 8'hxx;
      n_checks++;
      if (got !== exp_bytes[i]) begin n_fail++; $display("FAIL gap_byte%0d: got %h expected %h", i, got, exp_bytes[i]); end
    end
    low_len = 16;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_Start = 1'b0;
    test_reset();
    test_full_sequence();
    test_start_ignored();
    test_stalled_ready();
    test_reset_mid();
    test_back_to_back();
    test_min_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
